// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1 - oversampling UART receiver, 8 data bits, no parity, 1 stop bit.
//
// Turns the asynchronous serial line into one-cycle byte strobes for the debug
// core's byte-stream input, and flags frames whose stop bit is low.
//
// Ports:
//   clk           in   system clock, all logic on the rising edge
//   rst           in   synchronous reset, active-high
//   rx            in   asynchronous serial line, idles high
//   data          out  [7:0] last correctly received byte, held until the next good frame
//   valid         out  one-cycle strobe, data is new in this cycle
//   framing_error out  one-cycle strobe, stop bit was sampled low
//   busy          out  high whenever the receiver is not idle
//
// Timing: with t0 the first cycle IDLE sees the synchronised line low, the start
// bit is checked at t0 + CLOCKS_PER_BAUD/2, data bit k (k = 1..8) at
// t0 + CLOCKS_PER_BAUD/2 + k*CLOCKS_PER_BAUD and the stop bit one baud later.
// The strobe follows the stop-bit sample by one cycle.

module uart_rx_8n1 #(
  parameter int unsigned CLOCKS_PER_BAUD = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int unsigned CntW = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
  // Counter terminal values: the counter runs from 0, so "last" is N-1.
  localparam logic [CntW-1:0] HalfLast = CntW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLOCKS_PER_BAUD - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  logic            r_sync1;
  logic            r_rx_s;
  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            r_busy;

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never fabricates a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      // Strobes are single-cycle by default.
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (!r_rx_s) begin
            r_state <= StStart;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        StStart: begin
          if (r_cnt == HalfLast) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state   <= StData;
              r_bit_idx <= '0;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end

        StData: begin
          if (r_cnt == BaudLast) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};  // LSB arrives first
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= StStop;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end

        StStop: begin
          if (r_cnt == BaudLast) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= StBreak;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end

        StBreak: begin
          // Hold off until the line returns high so a long break reports once.
          if (r_rx_s) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data          = r_data;
  assign valid         = r_valid;
  assign framing_error = r_ferr;
  assign busy          = r_busy;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1: three instances (4, 8 and 868 clocks per baud).
// Stimulus pushes the expected strobe; a negedge monitor pops and compares.

module tb_uart_rx_8n1;

  localparam int unsigned Half   = 500;
  localparam int unsigned Period = 2 * Half;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rx4   = 1'b1;
  logic rx8   = 1'b1;
  logic rx868 = 1'b1;

  logic [7:0] d4, d8, d868;
  logic       v4, v8, v868;
  logic       fe4, fe8, fe868;
  logic       bz4, bz8, bz868;

  always #(Half) clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [7:0]  data;
    int unsigned t_exp;  // 0 = no timing check
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t q868[$];

  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good[3];

  uart_rx_8n1 #(.CLOCKS_PER_BAUD(4)) u_dut4 (
    .clk(clk), .rst(rst), .rx(rx4), .data(d4), .valid(v4),
    .framing_error(fe4), .busy(bz4)
  );
  uart_rx_8n1 #(.CLOCKS_PER_BAUD(8)) u_dut8 (
    .clk(clk), .rst(rst), .rx(rx8), .data(d8), .valid(v8),
    .framing_error(fe8), .busy(bz8)
  );
  uart_rx_8n1 #(.CLOCKS_PER_BAUD(868)) u_dut868 (
    .clk(clk), .rst(rst), .rx(rx868), .data(d868), .valid(v868),
    .framing_error(fe868), .busy(bz868)
  );

  function automatic int cpb_of(input int idx);
    case (idx)
      0:       return 4;
      1:       return 8;
      default: return 868;
    endcase
  endfunction

  task automatic drive_rx(input int idx, input logic v);
    case (idx)
      0:       rx4 = v;
      1:       rx8 = v;
      default: rx868 = v;
    endcase
  endtask

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // kind: 0 = no strobe expected, 1 = good byte, 2 = framing error.
  // align: start the frame 100 time units before a rising edge; otherwise start
  // immediately (back-to-back). skew_pm is baud skew in parts per thousand.
  task automatic send_frame(input int idx, input logic [7:0] b, input int skew_pm,
                            input logic stop_v, input logic align, input int kind,
                            input logic chk_t);
    int   bit_t;
    exp_t e;
    bit_t = cpb_of(idx) * int'(Period) * (1000 + skew_pm) / 1000;
    if (align) begin
      @(posedge clk);
      #(Period - 100);
    end
    if (kind != 0) begin
      e.err  = (kind == 2);
      e.data = (kind == 2) ? last_good[idx] : b;
      // 2 synchroniser cycles to t0, then valid at t0 + 77 for 8 clocks/baud.
      e.t_exp = chk_t ? cyc + 79 : 0;
      case (idx)
        0:       q4.push_back(e);
        1:       q8.push_back(e);
        default: q868.push_back(e);
      endcase
      if (kind == 1) last_good[idx] = b;
    end
    drive_rx(idx, 1'b0);
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      drive_rx(idx, b[i]);
      #(bit_t);
    end
    drive_rx(idx, stop_v);
    #(bit_t);
  endtask

  task automatic mon(input int idx, input logic v, input logic fe, input logic [7:0] d);
    exp_t e;
    int   n;
    if (!v && !fe) return;
    checks++;
    if (v && fe) begin
      errors++;
      $display("FAIL strobe_overlap dut%0d: valid=1 framing_error=1, required at most one", idx);
      return;
    end
    case (idx)
      0:       n = q4.size();
      1:       n = q8.size();
      default: n = q868.size();
    endcase
    if (n == 0) begin
      errors++;
      $display("FAIL unexpected_strobe dut%0d: valid=%0b framing_error=%0b data=0x%02h, required none",
               idx, v, fe, d);
      return;
    end
    case (idx)
      0:       e = q4.pop_front();
      1:       e = q8.pop_front();
      default: e = q868.pop_front();
    endcase
    if (e.err != fe || e.data != d || (e.t_exp != 0 && e.t_exp != cyc)) begin
      errors++;
      $display("FAIL frame dut%0d: got ferr=%0b data=0x%02h cycle=%0d, required ferr=%0b data=0x%02h cycle=%0d",
               idx, fe, d, cyc, e.err, e.data, e.t_exp);
    end
  endtask

  always @(negedge clk) begin
    mon(0, v4, fe4, d4);
    mon(1, v8, fe8, d8);
    mon(2, v868, fe868, d868);
  end

  initial begin
    #(200_000_000);
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 3; i++) last_good[i] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", 32'(d8), 32'h00);
    check("reset_valid", 32'(v8), 0);
    check("reset_ferr", 32'(fe8), 0);
    check("reset_busy", 32'(bz8), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Ideal 0x55, strobe at t0 + 77
    send_frame(1, 8'h55, 0, 1'b1, 1'b1, 1, 1'b1);
    repeat (20) @(posedge clk);

    // Back-to-back 0xA3, 0x0F: strobes 80 cycles apart
    send_frame(1, 8'hA3, 0, 1'b1, 1'b1, 1, 1'b1);
    send_frame(1, 8'h0F, 0, 1'b1, 1'b0, 1, 1'b1);
    repeat (20) @(posedge clk);

    // Two-cycle glitch: no strobe, busy for exactly 4 cycles
    @(posedge clk);
    #(Period - 100);
    rx8 = 1'b0;
    n = 0;
    fork
      begin
        #(2 * Period);
        rx8 = 1'b1;
      end
      begin
        for (int i = 0; i < 24; i++) begin
          @(negedge clk);
          if (bz8) n++;
        end
      end
    join
    check("glitch_busy_cycles", n, 4);
    repeat (10) @(posedge clk);

    // 0x3C with low stop bit, break of 30 cycles, then good 0x81
    send_frame(1, 8'h3C, 0, 1'b0, 1'b1, 2, 1'b1);
    #(30 * Period);
    rx8 = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(1, 8'h81, 0, 1'b1, 1'b1, 1, 1'b1);
    repeat (20) @(posedge clk);

    // Reset in the middle of a 0xFF frame: aborted frame gives no strobe
    fork
      send_frame(1, 8'hFF, 0, 1'b1, 1'b1, 0, 1'b0);
      begin
        repeat (30) @(posedge clk);
        #100 rst = 1'b1;
        @(posedge clk);
        #100 rst = 1'b0;
      end
    join
    for (int i = 0; i < 3; i++) last_good[i] = 8'h00;
    repeat (5) @(negedge clk);
    check("data_after_reset", 32'(d8), 32'h00);
    send_frame(1, 8'h12, 0, 1'b1, 1'b1, 1, 1'b1);
    repeat (20) @(posedge clk);

    // Baud skew sweep, alternating +3 % / -3 %
    fork
      begin
        for (int i4 = 0; i4 < 256; i4++)
          send_frame(0, 8'($urandom), (i4 % 2 == 1) ? 30 : -30, 1'b1, 1'b1, 1, 1'b0);
      end
      begin
        for (int i8 = 0; i8 < 256; i8++)
          send_frame(1, 8'($urandom), (i8 % 2 == 1) ? 30 : -30, 1'b1, 1'b1, 1, 1'b0);
      end
      begin
        for (int ib = 0; ib < 3; ib++)
          send_frame(2, 8'($urandom), (ib % 2 == 1) ? 30 : -30, 1'b1, 1'b1, 1, 1'b0);
      end
    join
    repeat (100) @(posedge clk);

    check("pending_dut4", q4.size(), 0);
    check("pending_dut8", q8.size(), 0);
    check("pending_dut868", q868.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
